sub26_pipe: RTL and testbench
=============================

SUB26_PIPE -- requirements
Module: sub26_pipe

Interface
REQ-001: Parameters SHALL be none; operand width is fixed at 26 bits, split into two 13-bit halves.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: a  input  26  minuend.
REQ-005: b  input  26  subtrahend.
REQ-006: bin  input  1  borrow-in.
REQ-007: in_valid  input  1  a/b/bin valid this cycle.
REQ-008: in_ready  output  1  block accepts an operand set this cycle.
REQ-009: diff  output  26  result, a - b - bin modulo 2^26.
REQ-010: bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
REQ-011: out_valid  output  1  diff/bout valid.
REQ-012: out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-013: Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out SHALL occur on a cycle with out_valid && out_ready.
REQ-014: Stage 1 SHALL, on accept, register diff[12:0] = a[12:0] - b[12:0] - bin, the low-half borrow, a[25:13], b[25:13], and set s1_valid.
REQ-015: Stage 2 SHALL register diff[25:13] = a[25:13] - b[25:13] - low-half borrow, the high-half borrow as bout, the stage-1 low half unchanged, and set s2_valid.
REQ-016: Latency SHALL be exactly 2 cycles: operands accepted at edge N appear with out_valid=1 after edge N+1 when not stalled.
REQ-017: Throughput SHALL be one result per cycle while out_ready=1.
REQ-018: out_valid SHALL equal s2_valid; diff/bout SHALL be driven directly from stage-2 registers.
REQ-019: Stage 2 SHALL load when !s2_valid || out_ready; s2_valid SHALL clear on a transfer out with no stage-1 data advancing.
REQ-020: Stage 1 SHALL advance to stage 2 when s1_valid and stage 2 loads; s1_valid SHALL clear when it advances and no new accept occurs.
REQ-021: in_ready SHALL equal !s1_valid || (!s2_valid || out_ready); combinational from state and out_ready, never from in_valid.
REQ-022: Simultaneous transfer in and transfer out with both stages full SHALL advance both stages in the same cycle with no loss or duplication.
REQ-023: While out_valid=1 and out_ready=0, diff and bout SHALL remain stable.
REQ-024: Width rule: each half-subtraction SHALL be 14-bit unsigned, with the borrow taken as bit 13 of the inverted carry; results wrap modulo 2^13 per half.
REQ-025: Boundary: a=b with bin=1 SHALL give diff=26'h3FFFFFF and bout=1; a=0, b=0, bin=0 SHALL give diff=0 and bout=0.
REQ-026: Result ordering SHALL match acceptance order; no reordering.

Reset
REQ-027: On rst=1 at a rising edge, s1_valid and s2_valid SHALL clear; out_valid=0, in_ready=1 in the following cycle.
REQ-028: diff and bout SHALL reset to 0.
REQ-029: Reset mid-operation SHALL discard all in-flight operands; no result for them SHALL ever appear.
REQ-030: Input accepted in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-031: a=26'h0000123, b=26'h0000023, bin=0, out_ready=1 -> 2 cycles later diff=26'h0000100, bout=0.
REQ-032: a=26'h0002000, b=26'h0000001, bin=0 (borrow crosses the 13-bit split) -> diff=26'h0001FFF, bout=0.
REQ-033: a=0, b=26'h0000001, bin=1 -> diff=26'h3FFFFFE, bout=1.
REQ-034: Stream 8 back-to-back operand sets, then hold out_ready=0 for 3 cycles mid-stream -> in_ready drops once both stages are full, diff stays stable, all 8 results arrive in order with none lost or duplicated.
REQ-035: Assert rst for 1 cycle with both stages full -> out_valid=0 and in_ready=1 the next cycle, and the discarded results never appear.
REQ-036: Random 10k vectors with random in_valid/out_ready -> every {bout,diff} equals the reference ({1'b0,a} - {1'b0,b} - bin) taken modulo 2^27, with bout being the sign bit.

Source files
------------

// File: rtl/sub26_pipe.sv
// Two-stage pipelined 26-bit subtractor: the low 13-bit half is computed in stage 1
// and the high half in stage 2, with valid/ready handshakes on both sides.
module sub26_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] a,
    input  logic [25:0] b,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [25:0] diff,
    output logic        bout,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned HW = 13;
    localparam int unsigned SW = HW + 1;

    logic          s1_valid;
    logic [HW-1:0] s1_lo;
    logic          s1_borrow;
    logic [HW-1:0] s1_a_hi;
    logic [HW-1:0] s1_b_hi;
    logic          s2_valid;

    logic          s2_load;
    logic          s1_adv;
    logic          accept;
    logic [SW-1:0] lo_sub;
    logic [SW-1:0] hi_sub;

    // Handshake control and the two half-width subtractions; bit HW of each is the borrow.
    always_comb begin
        s2_load  = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_load;
        in_ready = !s1_valid || s2_load;
        accept   = in_valid && in_ready;
        lo_sub   = {1'b0, a[HW-1:0]} - {1'b0, b[HW-1:0]} - SW'(bin);
        hi_sub   = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - SW'(s1_borrow);
    end

    assign out_valid = s2_valid;

    // Stage 1: low half plus the raw high operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_borrow <= 1'b0;
            s1_a_hi   <= '0;
            s1_b_hi   <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_lo     <= lo_sub[HW-1:0];
            s1_borrow <= lo_sub[HW];
            s1_a_hi   <= a[25:HW];
            s1_b_hi   <= b[25:HW];
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2: high half and final borrow; holds its contents while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff <= {hi_sub[HW-1:0], s1_lo};
                bout <= hi_sub[HW];
            end
        end
    end

endmodule

// File: tb/tb_sub26_pipe.sv
// Randomized and directed bench for sub26_pipe against a queue-based reference of
// a - b - bin over 27 bits, tracking occupancy and per-item age for handshake timing.
module tb_sub26_pipe;

    logic        clk;
    logic        rst;
    logic [25:0] a;
    logic [25:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] diff;
    logic        bout;
    logic        out_valid;
    logic        out_ready;

    sub26_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          out_cnt  = 0;
    logic [26:0] exp_q[$];
    int          acc_q[$];
    logic        stall_prev = 1'b0;
    logic [26:0] held       = '0;
    logic        last_acc   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: drive on the falling edge, then judge what the next rising edge will transfer.
    task automatic step(input logic v, input logic [25:0] ai, input logic [25:0] bi,
                        input logic ci, input logic ordy, input logic r);
        logic [26:0] model;
        @(negedge clk);
        rst = r; in_valid = v; a = ai; b = bi; bin = ci; out_ready = ordy;
        #1;
        cyc++;
        last_acc = 1'b0;
        if (r) begin
            exp_q.delete();
            acc_q.delete();
            stall_prev = 1'b0;
            return;
        end
        check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
        if (exp_q.size() > 0)
            check("out_valid", 32'(out_valid), 32'((cyc - acc_q[0]) >= 2));
        else
            check("out_valid_idle", 32'(out_valid), 32'(0));
        if (stall_prev) check("hold_stable", 32'({bout, diff}), 32'(held));
        if (out_valid && ordy && exp_q.size() > 0) begin
            check("result", 32'({bout, diff}), 32'(exp_q.pop_front()));
            void'(acc_q.pop_front());
            out_cnt++;
        end
        if (v && in_ready) begin
            model = {1'b0, ai} - {1'b0, bi} - 27'(ci);
            exp_q.push_back(model);
            acc_q.push_back(cyc);
            last_acc = 1'b1;
        end
        stall_prev = out_valid && !ordy;
        held       = {bout, diff};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [25:0] sa[8];
    logic [25:0] sb[8];

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        step(1'b1, 26'h155, 26'h2, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_diff", 32'(diff), 32'(0));
        check("reset_bout", 32'(bout), 32'(0));

        // Single operand: two-cycle latency and known answers.
        step(1'b1, 26'h0000123, 26'h0000023, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("lat_out_valid", 32'(out_valid), 32'(1));
        check("basic_diff", 32'({bout, diff}), 32'(27'h0000100));
        step(1'b1, 26'h0002000, 26'h0000001, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("split_borrow", 32'({bout, diff}), 32'(27'h0001FFF));
        step(1'b1, 26'h0, 26'h0000001, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("underflow", 32'({bout, diff}), 32'({1'b1, 26'h3FFFFFE}));
        step(1'b1, 26'h1234567, 26'h1234567, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("equal_bin", 32'({bout, diff}), 32'({1'b1, 26'h3FFFFFF}));
        step(1'b1, 26'h0, 26'h0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("zero", 32'({bout, diff}), 32'(0));
        idle(2);

        // Eight back-to-back operands with a three-cycle downstream stall in the middle.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 26'($urandom);
            sb[i] = 26'($urandom);
        end
        out_cnt = 0;
        begin
            int k = 0;
            int s = 0;
            while (k < 8 && s < 40) begin
                step(1'b1, sa[k], sb[k], k[0], !(s >= 4 && s <= 6), 1'b0);
                if (s == 6) check("stall_in_ready", 32'(in_ready), 32'(0));
                if (last_acc) k++;
                s++;
            end
            check("stream_all_accepted", 32'(k), 32'(8));
        end
        idle(4);
        check("stream_count", 32'(out_cnt), 32'(8));

        // Reset with both stages full; in-flight data and the reset-cycle input vanish.
        step(1'b1, 26'h3000000, 26'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 26'h2000000, 26'h2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 26'h1000000, 26'h3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 26'h0ABCDEF, 26'h4, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("rst_mid_out_valid", 32'(out_valid), 32'(0));
        check("rst_mid_in_ready", 32'(in_ready), 32'(1));
        idle(4);

        // Random traffic with random handshakes.
        for (int i = 0; i < 10000; i++) begin
            logic [25:0] ra;
            logic [25:0] rb;
            ra = 26'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 26'($urandom);
            if ($urandom_range(0, 15) == 0) ra = '0;
            step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        end
        idle(5);
        check("drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
